// File: rtl/ecc_51_pkg.sv
// Shared types, constants and parity helper for the 51-bit SECDED path.
// The mask table is derived from the codeword layout at elaboration time.
package ecc_51_pkg;

   localparam int DATA_WIDTH   = 51;
   localparam int PARITY_WIDTH = 7;
   localparam int CODE_LEN     = 57;

   typedef logic [DATA_WIDTH-1:0]   data_t;
   typedef logic [PARITY_WIDTH-1:0] par_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } skid_e;

   typedef struct packed {
      logic  fault;
      par_t  parity;
      data_t data;
   } beat_t;

   // Row k lists the data bits feeding parity bit k.
   // Row 6 folds the overall parity: a data bit lands in it once
   // directly and once per check bit it feeds, so it survives only
   // when its position has an even number of ones.
   function automatic data_t hmat_row(input int k);
      data_t row;
      int    idx;
      row = '0;
      idx = 0;
      for (int pos = 1; pos <= CODE_LEN; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            if (k < 6)
               row[idx[5:0]] = ((pos >> k) & 1) != 0;
            else
               row[idx[5:0]] = ~^pos[5:0];
            idx++;
         end
      end
      return row;
   endfunction

   localparam data_t ECC51_HMAT [PARITY_WIDTH] = '{
      hmat_row(0), hmat_row(1), hmat_row(2), hmat_row(3),
      hmat_row(4), hmat_row(5), hmat_row(6)
   };

   function automatic par_t ecc51_parity(input data_t data);
      par_t p;
      p[0] = ^(data & ECC51_HMAT[0]);
      p[1] = ^(data & ECC51_HMAT[1]);
      p[2] = ^(data & ECC51_HMAT[2]);
      p[3] = ^(data & ECC51_HMAT[3]);
      p[4] = ^(data & ECC51_HMAT[4]);
      p[5] = ^(data & ECC51_HMAT[5]);
      p[6] = ^(data & ECC51_HMAT[6]);
      return p;
   endfunction

endpackage

// File: rtl/ecc_51_enc_wr_if.sv
// Write-beat handshake, injection controls and fault status bundle.
// slave faces the encoder stage, master faces the producer/FIFO side.
interface ecc_51_enc_wr_if #(
   parameter int FCNT_WIDTH = 8
);
   import ecc_51_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   data_t                 in_data;
   logic                  out_valid;
   logic                  out_ready;
   data_t                 out_data;
   par_t                  out_parity;
   logic                  out_fault;
   logic                  ecc_fault_detc_en;
   logic                  inj_en;
   logic [1:0]            inj_mode;
   logic [5:0]            inj_pos0;
   logic [5:0]            inj_pos1;
   logic                  inj_done;
   logic                  fault_sticky;
   logic [FCNT_WIDTH-1:0] fault_cnt;
   logic                  fault_clr;

   modport master (
      output in_valid, in_data, out_ready,
      output ecc_fault_detc_en, inj_en, inj_mode,
      output inj_pos0, inj_pos1, fault_clr,
      input  in_ready, out_valid, out_data,
      input  out_parity, out_fault, inj_done,
      input  fault_sticky, fault_cnt
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      input  ecc_fault_detc_en, inj_en, inj_mode,
      input  inj_pos0, inj_pos1, fault_clr,
      output in_ready, out_valid, out_data,
      output out_parity, out_fault, inj_done,
      output fault_sticky, fault_cnt
   );

endinterface

// File: rtl/ecc_51_enc.sv
// Combinational SECDED parity generator, 51 data bits -> 7 parity bits.
// Instantiated twice by the write stage for self-checking.
module ecc_51_enc
   import ecc_51_pkg::*;
(
   input  data_t data,
   output par_t  parity
);

   assign parity = ecc51_parity(data);

endmodule

// File: rtl/ecc_51_enc_wr.sv
// Write-side SECDED encoder stage: dual encoders, 2-entry skid buffer,
// one-shot error injection and saturating fault accounting.
module ecc_51_enc_wr
   import ecc_51_pkg::*;
#(
   parameter int FCNT_WIDTH = 8
)(
   input logic            clk,
   input logic            rst,
   ecc_51_enc_wr_if.slave bus
);

   skid_e state_q;
   skid_e state_d;
   beat_t head_q;
   beat_t tail_q;
   beat_t beat_in;
   logic  in_ready_q;
   logic  accept;
   logic  head_ld;
   logic  head_from_tail;
   logic  tail_ld;

   par_t  par0;
   (* keep = "true", dont_touch = "true" *)
   par_t  par1;
   logic  compare_ok;
   logic  new_fault;

   data_t pos0_mask;
   data_t pos1_mask;
   data_t inj_mask;
   logic  inj_hit;
   logic  inj_spent_q;
   logic  inj_done_q;

   logic                  fault_sticky_q;
   logic [FCNT_WIDTH-1:0] fault_cnt_q;

   ecc_51_enc u0 (
      .data   (bus.in_data),
      .parity (par0)
   );

   (* keep = "true", dont_touch = "true" *)
   ecc_51_enc u1 (
      .data   (bus.in_data),
      .parity (par1)
   );

   assign accept     = bus.in_valid & in_ready_q;
   assign compare_ok = (par0 == par1) | ~bus.ecc_fault_detc_en;
   assign new_fault  = accept & ~compare_ok;

   // Decode the flip mask for the armed beat; out-of-range indices flip nothing.
   always_comb begin
      pos0_mask = '0;
      pos1_mask = '0;
      inj_mask  = '0;
      inj_hit   = 1'b0;
      if (bus.inj_pos0 < 6'(DATA_WIDTH))
         pos0_mask = data_t'(1) << bus.inj_pos0;
      if (bus.inj_pos1 < 6'(DATA_WIDTH))
         pos1_mask = data_t'(1) << bus.inj_pos1;
      if (bus.inj_en & ~inj_spent_q) begin
         unique case (1'b1)
            bus.inj_mode == 2'b01: begin
               inj_hit  = 1'b1;
               inj_mask = pos0_mask;
            end
            bus.inj_mode == 2'b10: begin
               inj_hit  = 1'b1;
               inj_mask = pos0_mask ^ pos1_mask;
            end
            default: begin
               inj_hit  = 1'b0;
               inj_mask = '0;
            end
         endcase
      end
   end

   // Parity always comes from the clean data; only the payload is corrupted.
   always_comb begin
      beat_in.fault  = ~compare_ok;
      beat_in.parity = par0;
      beat_in.data   = bus.in_data ^ inj_mask;
   end

   // Skid occupancy next-state and buffer load selects.
   always_comb begin
      state_d        = state_q;
      head_ld        = 1'b0;
      head_from_tail = 1'b0;
      tail_ld        = 1'b0;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = ONE;
               head_ld = 1'b1;
            end
         end
         ONE: begin
            if (accept & bus.out_ready) begin
               head_ld = 1'b1;
            end else if (accept) begin
               state_d = FULL;
               tail_ld = 1'b1;
            end else if (bus.out_ready) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (bus.out_ready) begin
               state_d        = ONE;
               head_from_tail = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // Occupancy register; in_ready is registered from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != FULL);
      end
   end

   // Head/tail beat storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         if (head_ld)
            head_q <= beat_in;
         else if (head_from_tail)
            head_q <= tail_q;
         if (tail_ld)
            tail_q <= beat_in;
      end
   end

   // One-shot arm: spent after an injected accept, re-armed when inj_en drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inj_spent_q <= 1'b1;
         inj_done_q  <= 1'b0;
      end else begin
         inj_done_q <= accept & inj_hit;
         if (~bus.inj_en)
            inj_spent_q <= 1'b0;
         else if (accept & inj_hit)
            inj_spent_q <= 1'b1;
      end
   end

   // Fault status; a new fault wins over a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fault_sticky_q <= 1'b0;
         fault_cnt_q    <= '0;
      end else begin
         if (new_fault)
            fault_sticky_q <= 1'b1;
         else if (bus.fault_clr)
            fault_sticky_q <= 1'b0;
         if (bus.fault_clr)
            fault_cnt_q <= new_fault ? FCNT_WIDTH'(1) : '0;
         else if (new_fault & ~&fault_cnt_q)
            fault_cnt_q <= fault_cnt_q + FCNT_WIDTH'(1);
      end
   end

   assign bus.in_ready     = in_ready_q;
   assign bus.out_valid    = (state_q != EMPTY);
   assign bus.out_data     = head_q.data;
   assign bus.out_parity   = head_q.parity;
   assign bus.out_fault    = head_q.fault;
   assign bus.inj_done     = inj_done_q;
   assign bus.fault_sticky = fault_sticky_q;
   assign bus.fault_cnt    = fault_cnt_q;

endmodule

// File: tb/tb_ecc_51_enc_wr.sv
// Randomized self-checking bench for ecc_51_enc_wr.
// Reference parity is built directly from codeword positions.
module tb_ecc_51_enc_wr;

   typedef struct packed {
      logic [50:0] d;
      logic [6:0]  p;
   } exp_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;
   exp_t q[$];

   ecc_51_enc_wr_if #(.FCNT_WIDTH(8)) bus ();

   ecc_51_enc_wr #(.FCNT_WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] ref_parity(input logic [50:0] d);
      logic [6:0] p;
      int idx;
      p = '0;
      idx = 0;
      for (int pos = 1; pos <= 57; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            if (d[idx]) p[5:0] = p[5:0] ^ 6'(pos);
            idx++;
         end
      end
      p[6] = (^d) ^ (^p[5:0]);
      return p;
   endfunction

   function automatic logic [50:0] rnd51();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[50:0];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = 1'b0;
      bus.ecc_fault_detc_en = 1'b1;
      bus.inj_en = 1'b0;
      bus.inj_mode = 2'b00;
      bus.inj_pos0 = '0;
      bus.inj_pos1 = '0;
      bus.fault_clr = 1'b0;
      repeat (3) step();
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
         n_bad++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid);
      end
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
         n_bad++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready);
      end
      n_cmp++;
      if (bus.out_data !== 51'h0 || bus.out_parity !== 7'h0) begin
         n_bad++;
         $display("FAIL rst_out_bus got=%h/%h exp=0/0", bus.out_data, bus.out_parity);
      end
      n_cmp++;
      if ({bus.out_fault, bus.inj_done, bus.fault_sticky} !== 3'b000) begin
         n_bad++;
         $display("FAIL rst_flags got=%b%b%b exp=000", bus.out_fault, bus.inj_done, bus.fault_sticky);
      end
      n_cmp++;
      if (bus.fault_cnt !== 8'd0) begin
         n_bad++; $display("FAIL rst_fault_cnt got=%0d exp=0", bus.fault_cnt);
      end
      rst = 1'b0;
      step();
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
         n_bad++; $display("FAIL post_rst_valid got=%b exp=0", bus.out_valid);
      end
   endtask

   task automatic test_basic();
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data = '0;
      step();
      bus.in_data = 51'h1;
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_parity !== 7'h00 || bus.out_fault !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_zero got v=%b p=%h f=%b exp v=1 p=00 f=0",
                  bus.out_valid, bus.out_parity, bus.out_fault);
      end
      step();
      bus.in_valid = 1'b0;
      n_cmp++;
      if (bus.out_data !== 51'h1 || bus.out_parity !== 7'h43) begin
         n_bad++;
         $display("FAIL basic_one got d=%h p=%h exp d=1 p=43", bus.out_data, bus.out_parity);
      end
      step();
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
         n_bad++; $display("FAIL basic_drained got=%b exp=0", bus.out_valid);
      end
   endtask

   task automatic test_random();
      int   acc_n;
      int   cyc;
      logic acc;
      logic drn;
      logic [50:0] d;
      exp_t e;
      acc_n = 0;
      cyc = 0;
      q.delete();
      while (acc_n < 10000 && cyc < 40000) begin
         bus.in_valid = ($urandom_range(3) != 0);
         d = ($urandom_range(15) == 0) ? '1 : rnd51();
         bus.in_data = d;
         bus.out_ready = ($urandom_range(3) != 0);
         n_cmp++;
         if (bus.in_ready !== (q.size() < 2)) begin
            n_bad++;
            $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready, q.size() < 2);
         end
         n_cmp++;
         if (bus.out_valid !== (q.size() != 0)) begin
            n_bad++;
            $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, q.size() != 0);
         end
         if (q.size() != 0) begin
            n_cmp++;
            if (bus.out_data !== q[0].d || bus.out_parity !== q[0].p || bus.out_fault !== 1'b0) begin
               n_bad++;
               $display("FAIL rnd_beat cyc=%0d got=%h/%h/%b exp=%h/%h/0", cyc,
                        bus.out_data, bus.out_parity, bus.out_fault, q[0].d, q[0].p);
            end
         end
         acc = bus.in_valid && (q.size() < 2);
         drn = bus.out_ready && (q.size() != 0);
         step();
         cyc++;
         if (drn) void'(q.pop_front());
         if (acc) begin
            e.d = d;
            e.p = ref_parity(d);
            q.push_back(e);
            acc_n++;
         end
      end
      n_cmp++;
      if (acc_n < 10000) begin
         n_bad++; $display("FAIL rnd_budget got=%0d beats exp=10000", acc_n);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4 && q.size() != 0; i++) begin
         n_cmp++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== q[0].d || bus.out_parity !== q[0].p) begin
            n_bad++;
            $display("FAIL rnd_drain got=%b/%h/%h exp=1/%h/%h", bus.out_valid,
                     bus.out_data, bus.out_parity, q[0].d, q[0].p);
         end
         void'(q.pop_front());
         step();
      end
      n_cmp++;
      if (bus.out_valid !== 1'b0 || q.size() != 0) begin
         n_bad++;
         $display("FAIL rnd_empty got valid=%b left=%0d exp=0/0", bus.out_valid, q.size());
      end
   endtask

   task automatic test_back_to_back();
      logic [50:0] d[3];
      logic [50:0] got[$];
      int k;
      logic acc;
      for (int i = 0; i < 3; i++) d[i] = rnd51();
      k = 0;
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data = d[0];
      for (int cyc = 0; cyc < 5; cyc++) begin
         if (cyc >= 2) begin
            n_cmp++;
            if (bus.in_ready !== 1'b0) begin
               n_bad++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", cyc, bus.in_ready);
            end
         end
         if (cyc >= 1) begin
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== d[0] || bus.out_parity !== ref_parity(d[0])) begin
               n_bad++;
               $display("FAIL bp_stable cyc=%0d got=%b/%h exp=1/%h", cyc, bus.out_valid, bus.out_data, d[0]);
            end
         end
         acc = bus.in_valid & bus.in_ready;
         step();
         if (acc) begin
            k++;
            if (k < 3) bus.in_data = d[k];
            else bus.in_valid = 1'b0;
         end
      end
      n_cmp++;
      if (k !== 2) begin
         n_bad++; $display("FAIL bp_accepts got=%0d exp=2", k);
      end
      bus.out_ready = 1'b1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (bus.out_valid & bus.out_ready) got.push_back(bus.out_data);
         acc = bus.in_valid & bus.in_ready;
         step();
         if (acc) begin
            k++;
            if (k < 3) bus.in_data = d[k];
            else bus.in_valid = 1'b0;
         end
      end
      n_cmp++;
      if (got.size() != 3) begin
         n_bad++; $display("FAIL bp_count got=%0d exp=3", got.size());
      end
      for (int i = 0; i < 3 && i < got.size(); i++) begin
         n_cmp++;
         if (got[i] !== d[i]) begin
            n_bad++; $display("FAIL bp_order idx=%0d got=%h exp=%h", i, got[i], d[i]);
         end
      end
   endtask

   task automatic test_inject();
      logic [50:0] r;
      bus.out_ready = 1'b1;
      bus.inj_en = 1'b1;
      bus.inj_mode = 2'b01;
      bus.inj_pos0 = 6'd7;
      bus.inj_pos1 = 6'd0;
      bus.in_valid = 1'b1;
      bus.in_data = '0;
      step();
      n_cmp++;
      if (bus.out_data !== 51'h80 || bus.out_parity !== 7'h00 || bus.inj_done !== 1'b1) begin
         n_bad++;
         $display("FAIL inj_single got=%h/%h/%b exp=80/00/1", bus.out_data, bus.out_parity, bus.inj_done);
      end
      step();
      bus.in_valid = 1'b0;
      n_cmp++;
      if (bus.out_data !== 51'h0 || bus.inj_done !== 1'b0) begin
         n_bad++;
         $display("FAIL inj_next_clean got=%h/%b exp=0/0", bus.out_data, bus.inj_done);
      end
      bus.inj_en = 1'b0;
      step();
      r = rnd51();
      bus.inj_en = 1'b1;
      bus.inj_mode = 2'b10;
      bus.inj_pos0 = 6'd3;
      bus.inj_pos1 = 6'd60;
      bus.in_valid = 1'b1;
      bus.in_data = r;
      step();
      bus.in_valid = 1'b0;
      bus.inj_en = 1'b0;
      n_cmp++;
      if (bus.out_data !== (r ^ 51'h8) || bus.out_parity !== ref_parity(r) || bus.inj_done !== 1'b1) begin
         n_bad++;
         $display("FAIL inj_double_oob got=%h/%h/%b exp=%h/%h/1", bus.out_data,
                  bus.out_parity, bus.inj_done, r ^ 51'h8, ref_parity(r));
      end
      step();
      n_cmp++;
      if (bus.inj_done !== 1'b0) begin
         n_bad++; $display("FAIL inj_pulse_width got=%b exp=0", bus.inj_done);
      end
      r = rnd51();
      bus.inj_en = 1'b1;
      bus.inj_pos0 = 6'd20;
      bus.inj_pos1 = 6'd20;
      bus.in_valid = 1'b1;
      bus.in_data = r;
      step();
      bus.in_valid = 1'b0;
      bus.inj_en = 1'b0;
      n_cmp++;
      if (bus.out_data !== r || bus.inj_done !== 1'b1) begin
         n_bad++;
         $display("FAIL inj_same_pos got=%h/%b exp=%h/1", bus.out_data, bus.inj_done, r);
      end
      step();
      r = rnd51();
      bus.inj_en = 1'b1;
      bus.inj_mode = 2'b11;
      bus.inj_pos0 = 6'd5;
      bus.in_valid = 1'b1;
      bus.in_data = r;
      step();
      bus.in_valid = 1'b0;
      bus.inj_en = 1'b0;
      bus.inj_mode = 2'b00;
      n_cmp++;
      if (bus.out_data !== r || bus.inj_done !== 1'b0) begin
         n_bad++;
         $display("FAIL inj_mode11 got=%h/%b exp=%h/0", bus.out_data, bus.inj_done, r);
      end
      step();
   endtask

   task automatic test_fault();
      bus.out_ready = 1'b1;
      bus.in_data = '0;
      bus.ecc_fault_detc_en = 1'b1;
      force dut.par1 = 7'h01;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if (bus.out_valid !== 1'b1 || bus.out_fault !== 1'b1) begin
            n_bad++;
            $display("FAIL flt_beat idx=%0d got=%b/%b exp=1/1", i, bus.out_valid, bus.out_fault);
         end
      end
      bus.in_valid = 1'b0;
      step();
      n_cmp++;
      if (bus.fault_sticky !== 1'b1 || bus.fault_cnt !== 8'd3) begin
         n_bad++;
         $display("FAIL flt_cnt3 got=%b/%0d exp=1/3", bus.fault_sticky, bus.fault_cnt);
      end
      bus.fault_clr = 1'b1;
      step();
      bus.fault_clr = 1'b0;
      n_cmp++;
      if (bus.fault_sticky !== 1'b0 || bus.fault_cnt !== 8'd0) begin
         n_bad++;
         $display("FAIL flt_clear got=%b/%0d exp=0/0", bus.fault_sticky, bus.fault_cnt);
      end
      bus.ecc_fault_detc_en = 1'b0;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if (bus.out_fault !== 1'b0) begin
            n_bad++; $display("FAIL flt_disabled idx=%0d got=%b exp=0", i, bus.out_fault);
         end
      end
      bus.in_valid = 1'b0;
      step();
      n_cmp++;
      if (bus.fault_sticky !== 1'b0 || bus.fault_cnt !== 8'd0) begin
         n_bad++;
         $display("FAIL flt_dis_cnt got=%b/%0d exp=0/0", bus.fault_sticky, bus.fault_cnt);
      end
      bus.ecc_fault_detc_en = 1'b1;
      bus.in_valid = 1'b1;
      repeat (300) step();
      bus.in_valid = 1'b0;
      step();
      n_cmp++;
      if (bus.fault_cnt !== 8'd255 || bus.fault_sticky !== 1'b1) begin
         n_bad++;
         $display("FAIL flt_saturate got=%0d/%b exp=255/1", bus.fault_cnt, bus.fault_sticky);
      end
      bus.fault_clr = 1'b1;
      bus.in_valid = 1'b1;
      step();
      bus.fault_clr = 1'b0;
      bus.in_valid = 1'b0;
      n_cmp++;
      if (bus.fault_cnt !== 8'd1 || bus.fault_sticky !== 1'b1) begin
         n_bad++;
         $display("FAIL flt_clr_race got=%0d/%b exp=1/1", bus.fault_cnt, bus.fault_sticky);
      end
      step();
   endtask

   task automatic test_reset_full();
      logic [50:0] r;
      bus.out_ready = 1'b0;
      bus.in_data = '0;
      bus.in_valid = 1'b1;
      repeat (2) step();
      bus.in_valid = 1'b0;
      n_cmp++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.fault_cnt !== 8'd3) begin
         n_bad++;
         $display("FAIL rf_full got=%b/%b/%0d exp=0/1/3", bus.in_ready, bus.out_valid, bus.fault_cnt);
      end
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.fault_cnt !== 8'd0) begin
         n_bad++;
         $display("FAIL rf_async got=%b/%b/%0d exp=0/1/0", bus.out_valid, bus.in_ready, bus.fault_cnt);
      end
      release dut.par1;
      repeat (2) step();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      step();
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.fault_sticky !== 1'b0) begin
         n_bad++;
         $display("FAIL rf_release got=%b/%b exp=0/0", bus.out_valid, bus.fault_sticky);
      end
      r = rnd51();
      bus.in_valid = 1'b1;
      bus.in_data = r;
      step();
      bus.in_valid = 1'b0;
      n_cmp++;
      if (bus.out_data !== r || bus.out_parity !== ref_parity(r) || bus.out_fault !== 1'b0) begin
         n_bad++;
         $display("FAIL rf_resume got=%h/%h/%b exp=%h/%h/0", bus.out_data,
                  bus.out_parity, bus.out_fault, r, ref_parity(r));
      end
      step();
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_basic();
      test_random();
      test_back_to_back();
      test_inject();
      test_fault();
      test_reset_full();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
